stream_traffic_generator: RTL

Programmable AXI-Stream-style beat source for benchmarking stream consumers and the cycle/idle performance counters. Software or a control FSM pulses `start` with a beat count and a throttle pattern. The block emits `num_beats` beats with `last` on the final one, inserts programmed idle gaps between bursts, and reports beats sent and back-pressure stalls. It sits on the transmit side of a stream whose handshakes are measured downstream.

---
 rtl/stream_traffic_generator_pkg.sv | 7 +
 rtl/stream_traffic_generator.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/stream_traffic_generator_pkg.sv
// Shared types for the stream traffic generator.
//   data64_t : 64-bit beat-count / counter type used on the control interface.
package stream_traffic_generator_pkg;

  typedef logic [63:0] data64_t;

endpackage

// File: rtl/stream_traffic_generator.sv
// Programmable AXI-Stream-style beat source.
// A start pulse in idle latches a beat count, burst/gap throttle and a data seed, then
// emits num_beats beats (data = seed + beat index, last on the final beat), inserting
// idle_len empty cycles after every burst_len beats except after the final beat.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : run request, only honoured while idle
//   num_beats         : beats to send (0 completes immediately)
//   burst_len/idle_len: burst size and gap length; either at 0 disables gaps
//   seed              : data value of the first beat
//   m_valid/m_ready   : stream handshake; m_data/m_last are the beat payload
//   busy, done        : run in progress / one-cycle completion pulse
//   beats_sent        : handshakes in the current or last run
//   stall_cycles      : cycles with m_valid && !m_ready in the current or last run
module stream_traffic_generator
  import stream_traffic_generator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  data64_t               num_beats,
  input  logic [31:0]           burst_len,
  input  logic [31:0]           idle_len,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic [63:0]           beats_sent,
  output logic [63:0]           stall_cycles
);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e                state_q, state_d;
  data64_t               cfg_num_q, cfg_num_d;
  logic [31:0]           cfg_burst_q, cfg_burst_d;
  logic [31:0]           cfg_idle_q, cfg_idle_d;
  data64_t               idx_q, idx_d;
  logic [31:0]           burst_cnt_q, burst_cnt_d;
  logic [31:0]           gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;
  logic [63:0]           beats_q, beats_d;
  logic [63:0]           stall_q, stall_d;
  logic [31:0]           burst_next;
  logic                  gaps_en;

  assign gaps_en = (cfg_burst_q != 32'd0) && (cfg_idle_q != 32'd0);

  always_comb begin
    state_d     = state_q;
    cfg_num_d   = cfg_num_q;
    cfg_burst_d = cfg_burst_q;
    cfg_idle_d  = cfg_idle_q;
    idx_d       = idx_q;
    burst_cnt_d = burst_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    data_d      = data_q;
    last_d      = last_q;
    done_d      = 1'b0;
    beats_d     = beats_q;
    stall_d     = stall_q;
    burst_next  = burst_cnt_q + 32'd1;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          cfg_num_d   = num_beats;
          cfg_burst_d = burst_len;
          cfg_idle_d  = idle_len;
          beats_d     = '0;
          stall_d     = '0;
          burst_cnt_d = '0;
          idx_d       = '0;
          if (num_beats != 64'd0) begin
            state_d = StSend;
            data_d  = seed;
            last_d  = (num_beats == 64'd1);
          end else begin
            done_d = 1'b1;
          end
        end
      end

      StSend: begin
        if (!m_ready) begin
          stall_d = stall_q + 64'd1;
        end else begin
          beats_d = beats_q + 64'd1;
          if (last_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
            data_d  = '0;
            last_d  = 1'b0;
          end else begin
            idx_d  = idx_q + 64'd1;
            // Incrementing the held payload keeps m_data == seed + index (mod 2^W).
            data_d = data_q + DATA_WIDTH'(1);
            // The next beat is the last one when the new index equals num_beats - 1.
            last_d = ((idx_q + 64'd2) == cfg_num_q);
            if (gaps_en && (burst_next == cfg_burst_q)) begin
              state_d     = StGap;
              burst_cnt_d = '0;
              gap_cnt_d   = cfg_idle_q;
            end else begin
              burst_cnt_d = burst_next;
            end
          end
        end
      end

      StGap: begin
        // Leaving on a count of one gives exactly idle_len cycles in this state.
        if (gap_cnt_q <= 32'd1) begin
          state_d   = StSend;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - 32'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cfg_num_q   <= '0;
      cfg_burst_q <= '0;
      cfg_idle_q  <= '0;
      idx_q       <= '0;
      burst_cnt_q <= '0;
      gap_cnt_q   <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      beats_q     <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      cfg_num_q   <= cfg_num_d;
      cfg_burst_q <= cfg_burst_d;
      cfg_idle_q  <= cfg_idle_d;
      idx_q       <= idx_d;
      burst_cnt_q <= burst_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      data_q      <= data_d;
      last_q      <= last_d;
      done_q      <= done_d;
      beats_q     <= beats_d;
      stall_q     <= stall_d;
    end
  end

  assign m_valid      = (state_q == StSend);
  assign busy         = (state_q != StIdle);
  assign m_data       = data_q;
  assign m_last       = last_q;
  assign done         = done_q;
  assign beats_sent   = beats_q;
  assign stall_cycles = stall_q;

endmodule
